cp0_except: RTL and testbench

CP0_EXCEPT -- requirements
Module: cp0_except

---
 rtl/cp0_except_pkg.sv | 46 ++++
 rtl/cp0_timer.sv | 30 +++
 rtl/cp0_except.sv | 115 +++++++++++
 tb/tb_cp0_except.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_except_pkg.sv
// CP0 register addresses, exception codes and excepttype encodings,
// shared by cp0_except and the pipeline controller.
package cp0_except_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;

  // Bit positions of the MEM-stage exception flags
  localparam int RAW_SYSCALL = 8;
  localparam int RAW_INVALID = 9;
  localparam int RAW_TRAP    = 10;
  localparam int RAW_OVF     = 11;
  localparam int RAW_ERET    = 12;

  localparam logic [31:0] EXT_INT     = 32'h1;
  localparam logic [31:0] EXT_SYSCALL = 32'h8;
  localparam logic [31:0] EXT_INVALID = 32'ha;
  localparam logic [31:0] EXT_TRAP    = 32'hd;
  localparam logic [31:0] EXT_OVF     = 32'hc;
  localparam logic [31:0] EXT_ERET    = 32'he;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_INVALID = 5'd10;
  localparam logic [4:0] EXC_TRAP    = 5'd13;
  localparam logic [4:0] EXC_OVF     = 5'd12;

  function automatic logic [4:0] exc_code(input logic [31:0] et);
    case (et)
      EXT_SYSCALL: exc_code = EXC_SYSCALL;
      EXT_INVALID: exc_code = EXC_INVALID;
      EXT_TRAP:    exc_code = EXC_TRAP;
      EXT_OVF:     exc_code = EXC_OVF;
      default:     exc_code = EXC_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Free-running Count, Compare and the sticky timer interrupt it raises.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      // A Compare write is the only way to acknowledge the interrupt
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (compare != '0 && count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_except.sv
// CP0 register file plus MEM-stage exception resolution; Count/Compare
// live in cp0_timer.
module cp0_except
  import cp0_except_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_raw_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  logic [31:0] count, compare, status, cause, epc;
  logic [31:0] status_bp, cause_bp, epc_bp;
  logic [31:0] status_n, cause_n, epc_n;
  logic        exc_take, exc_eret, int_pend;
  logic        unused_ok;

  assign unused_ok = &{1'b0, int_i[5], excepttype_raw_i[31:13],
                       excepttype_raw_i[7:0]};

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_i && waddr_i == CP0_COUNT),
    .compare_we (we_i && waddr_i == CP0_COMPARE),
    .wdata      (wdata_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int_o)
  );

  // Same-cycle mtc0 forwarding so WB writes are seen by MEM resolution
  always_comb begin
    status_bp = (we_i && waddr_i == CP0_STATUS) ? wdata_i : status;
    cause_bp  = cause;
    if (we_i && waddr_i == CP0_CAUSE) cause_bp[9:8] = wdata_i[9:8];
    epc_bp    = (we_i && waddr_i == CP0_EPC) ? wdata_i : epc;
  end

  assign int_pend = |(cause_bp[15:8] & status_bp[15:8]) &&
                    !status_bp[ST_EXL] && status_bp[ST_IE];

  always_comb begin
    excepttype_o = '0;
    if (inst_addr_i != '0) begin
      if (int_pend)                          excepttype_o = EXT_INT;
      else if (excepttype_raw_i[RAW_SYSCALL]) excepttype_o = EXT_SYSCALL;
      else if (excepttype_raw_i[RAW_INVALID]) excepttype_o = EXT_INVALID;
      else if (excepttype_raw_i[RAW_TRAP])    excepttype_o = EXT_TRAP;
      else if (excepttype_raw_i[RAW_OVF])     excepttype_o = EXT_OVF;
      else if (excepttype_raw_i[RAW_ERET])    excepttype_o = EXT_ERET;
    end
  end

  assign exc_eret = (excepttype_o == EXT_ERET);
  assign exc_take = (excepttype_o != '0) && !exc_eret;

  // Exception side effects are applied on top of the bypassed values
  always_comb begin
    status_n = status_bp;
    cause_n  = cause_bp;
    epc_n    = epc_bp;
    cause_n[15:10] = {timer_int_o, int_i[4:0]};
    if (exc_take) begin
      status_n[ST_EXL] = 1'b1;
      cause_n[6:2]     = exc_code(excepttype_o);
      if (!status_bp[ST_EXL]) begin
        cause_n[CA_BD] = in_delayslot_i;
        epc_n = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
      end
    end else if (exc_eret) begin
      status_n[ST_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
    end else begin
      status <= status_n;
      cause  <= cause_n;
      epc    <= epc_n;
    end
  end

  always_comb begin
    case (raddr_i)
      CP0_COUNT:   rdata_o = count;
      CP0_COMPARE: rdata_o = compare;
      CP0_STATUS:  rdata_o = status;
      CP0_CAUSE:   rdata_o = cause;
      CP0_EPC:     rdata_o = epc;
      default:     rdata_o = '0;
    endcase
  end

  assign cp0_epc_o = epc_bp;
  assign status_o  = status;
  assign cause_o   = cause;

endmodule

// File: tb/tb_cp0_except.sv
// Directed checks of cp0_except: reset, timer, interrupt/exception entry,
// eret, bypassing, priority and reset mid-exception.
module tb_cp0_except;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_raw_i;
  logic [31:0] inst_addr_i;
  logic        in_delayslot_i;
  logic [31:0] excepttype_o;
  logic [31:0] cp0_epc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic        timer_int_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_except dut (
    .clk              (clk),
    .rst              (rst),
    .we_i             (we_i),
    .waddr_i          (waddr_i),
    .wdata_i          (wdata_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .int_i            (int_i),
    .excepttype_raw_i (excepttype_raw_i),
    .inst_addr_i      (inst_addr_i),
    .in_delayslot_i   (in_delayslot_i),
    .excepttype_o     (excepttype_o),
    .cp0_epc_o        (cp0_epc_o),
    .status_o         (status_o),
    .cause_o          (cause_o),
    .timer_int_o      (timer_int_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each read costs 1 ns; keep reads per cycle well under the 10 ns period
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr_i = a;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    excepttype_raw_i = '0; inst_addr_i = '0; in_delayslot_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raddr_i = '0; int_i = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_status", status_o, 32'h1000_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_timer", {31'd0, timer_int_o}, 32'h0);
    rd("rst_count", 5'd9, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);

    // Ten idle cycles
    repeat (10) tick();
    rd("count10", 5'd9, 32'd10);
    rd("bad_addr", 5'd3, 32'h0);
    chk("idle_et", excepttype_o, 32'h0);

    // Timer: Compare=20 written while Count=10
    mtc0(5'd11, 32'd20);
    tick(); idle();
    rd("compare", 5'd11, 32'd20);
    repeat (9) tick();
    rd("count20", 5'd9, 32'd20);
    chk("timer_not_yet", {31'd0, timer_int_o}, 32'h0);
    tick();
    chk("timer_set", {31'd0, timer_int_o}, 32'h1);
    tick();
    chk("cause_ip7", cause_o, 32'h0000_8000);

    // Interrupt beats a simultaneous syscall
    mtc0(5'd12, 32'h0000_8001);
    tick(); idle();
    excepttype_raw_i = 32'h100; inst_addr_i = 32'h100;
    #1;
    chk("int_et", excepttype_o, 32'h1);
    tick(); idle();
    rd("int_epc", 5'd14, 32'h100);
    chk("int_status", status_o, 32'h0000_8003);
    chk("int_cause", cause_o, 32'h0000_8000);

    // Compare write acknowledges the timer
    mtc0(5'd11, 32'd0);
    tick(); idle();
    chk("timer_clr", {31'd0, timer_int_o}, 32'h0);
    mtc0(5'd12, 32'h0);
    tick(); idle();

    // Syscall (+overflow) in a delay slot
    excepttype_raw_i = 32'h900; inst_addr_i = 32'h204; in_delayslot_i = 1'b1;
    #1;
    chk("sys_et", excepttype_o, 32'h8);
    tick(); idle();
    rd("sys_epc", 5'd14, 32'h200);
    chk("sys_cause", cause_o, 32'h8000_0020);
    chk("sys_status", status_o, 32'h0000_0002);

    // eret with same-cycle EPC write
    excepttype_raw_i = 32'h1000; inst_addr_i = 32'h208;
    mtc0(5'd14, 32'h300);
    #1;
    chk("eret_epc_o", cp0_epc_o, 32'h300);
    chk("eret_et", excepttype_o, 32'he);
    tick(); idle();
    chk("eret_status", status_o, 32'h0);
    rd("eret_epc", 5'd14, 32'h300);

    // Priority among MEM flags (no edge taken with them applied)
    inst_addr_i = 32'h400;
    excepttype_raw_i = 32'h1e00; #1;
    chk("pri_invalid", excepttype_o, 32'ha);
    excepttype_raw_i = 32'h1c00; #1;
    chk("pri_trap", excepttype_o, 32'hd);
    excepttype_raw_i = 32'h1800; #1;
    chk("pri_ovf", excepttype_o, 32'hc);
    excepttype_raw_i = 32'h1000; #1;
    chk("pri_eret", excepttype_o, 32'he);
    idle();
    tick();

    // Overflow while EXL=1: EPC/BD frozen, ExcCode updated
    mtc0(5'd12, 32'h2);
    tick(); idle();
    excepttype_raw_i = 32'h800; inst_addr_i = 32'h500;
    #1;
    chk("ovf_et", excepttype_o, 32'hc);
    tick(); idle();
    rd("ovf_epc", 5'd14, 32'h300);
    chk("ovf_cause", cause_o, 32'h8000_0030);
    excepttype_raw_i = 32'h800;
    #1;
    chk("bubble_et", excepttype_o, 32'h0);
    idle();
    tick();

    // Status write and syscall together: bypassed EXL=0, exception sets EXL
    mtc0(5'd12, 32'h0000_ff00);
    excepttype_raw_i = 32'h100; inst_addr_i = 32'h600;
    #1;
    chk("byp_et", excepttype_o, 32'h8);
    tick(); idle();
    chk("byp_status", status_o, 32'h0000_ff02);
    chk("byp_cause", cause_o, 32'h0000_0020);
    rd("byp_epc", 5'd14, 32'h600);

    // Only Cause[9:8] writable; IP sampled from int_i
    mtc0(5'd13, 32'hffff_ffff);
    int_i = 6'b100001;
    tick(); idle();
    int_i = '0;
    chk("cause_wr", cause_o, 32'h0000_0720);

    // Count load and wrap
    mtc0(5'd9, 32'hffff_ffff);
    tick(); idle();
    rd("count_load", 5'd9, 32'hffff_ffff);
    tick();
    rd("count_wrap", 5'd9, 32'h0);

    // Reset discards a pending exception and mtc0
    rst = 1'b1;
    mtc0(5'd12, 32'h1234);
    excepttype_raw_i = 32'h100; inst_addr_i = 32'h700;
    tick(); idle();
    rst = 1'b0;
    #1;
    chk("rst2_status", status_o, 32'h1000_0000);
    chk("rst2_cause", cause_o, 32'h0);
    rd("rst2_epc", 5'd14, 32'h0);
    rd("rst2_count", 5'd9, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
